uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 41 ++++
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the byte-stream and status signals between a UART receiver /
//   consumer pair and the receive FIFO.
//
//   Write side : wr_data, wr_valid
//   Read side  : rd_en, rd_data, rd_valid
//   Control    : clr_flags
//   Status     : empty, full, almost_full, count, overflow, underflow
//
//   Modports:
//     master - the environment side. It drives the writes, pops and
//              clr_flags, and observes the data and status.
//     slave  - the FIFO side.
interface uart_rx_fifo_if #(
   parameter int AW = 4
);
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        rd_en;
   logic        clr_flags;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        empty;
   logic        full;
   logic        almost_full;
   logic [AW:0] count;
   logic        overflow;
   logic        underflow;

   modport master (
      output wr_data, wr_valid, rd_en, clr_flags,
      input  rd_data, rd_valid, empty, full, almost_full, count,
             overflow, underflow
   );

   modport slave (
      input  wr_data, wr_valid, rd_en, clr_flags,
      output rd_data, rd_valid, empty, full, almost_full, count,
             overflow, underflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Byte FIFO that sits between a UART receiver and its consumer, such as
//   an LED controller or a host. The receiver strobes one byte per
//   wr_valid pulse. The consumer pops bytes with rd_en, and each accepted
//   pop returns its byte on rd_data one cycle later, qualified by a
//   one-cycle rd_valid strobe.
//
//   Ports:
//     clk    - system clock; all logic is rising-edge
//     reset  - synchronous, active-low reset
//     bus    - uart_rx_fifo_if slave modport:
//                wr_data/wr_valid       byte in, one byte per strobe
//                rd_en                  pop request
//                clr_flags              clears the sticky overflow/underflow flags
//                rd_data/rd_valid       popped byte, registered, latency 1
//                empty/full/almost_full registered occupancy flags
//                count                  entries stored, 0..DEPTH
//                overflow/underflow     sticky error flags
//
//   Parameters:
//     DEPTH     - number of entries (a power of two, 4..256)
//     AW        - pointer width, log2(DEPTH)
//     AFULL_LVL - count at or above which almost_full asserts
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int AFULL_LVL = 12
) (
   input  logic            clk,
   input  logic            reset,
   uart_rx_fifo_if.slave   bus
);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0] count_q;
   logic [AW:0] count_next;
   logic        empty_q;
   logic        full_q;
   logic        afull_q;
   logic        rd_valid_q;
   logic [7:0]  rd_data_q;
   logic        overflow_q;
   logic        underflow_q;

   logic        wr_accept;
   logic        rd_accept;
   logic        wr_drop;
   logic        rd_reject;

   // Accept and reject decisions use the registered flags, which reflect
   // the count before the edge. A write and a read in the same cycle on a
   // full FIFO therefore pop one byte and drop the write. On an empty FIFO
   // they store the write and reject the read.
   always_comb begin
      wr_accept = bus.wr_valid && !full_q;
      rd_accept = bus.rd_en && !empty_q;
      wr_drop   = bus.wr_valid && full_q;
      rd_reject = bus.rd_en && empty_q;
   end

   // Work out the next occupancy up front. The registered flags can then
   // be loaded from the same value as count and always agree with it.
   always_comb begin
      count_next = count_q;
      if (wr_accept && !rd_accept) begin
         count_next = count_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
         count_next = count_q - 1'b1;
      end
   end

   // The storage array has no reset. After a reset the pointers make any
   // old contents unreachable. The write is still gated by reset so that a
   // strobe that arrives during reset leaves no trace.
   always_ff @(posedge clk) begin
      if (reset && wr_accept) begin
         mem[wp] <= bus.wr_data;
      end
   end

   // Pointers, occupancy, read port and sticky flags. A new overflow or
   // underflow event in the same cycle as clr_flags takes priority, so the
   // flag stays set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wp          <= '0;
         rp          <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         afull_q     <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= 8'h00;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            wp <= wp + 1'b1;
         end
         if (rd_accept) begin
            rp        <= rp + 1'b1;
            rd_data_q <= mem[rp];
         end
         rd_valid_q  <= rd_accept;
         count_q     <= count_next;
         empty_q     <= (count_next == '0);
         full_q      <= (count_next == DEPTH_CNT);
         afull_q     <= (count_next >= AFULL_CNT);
         overflow_q  <= wr_drop || (overflow_q && !bus.clr_flags);
         underflow_q <= rd_reject || (underflow_q && !bus.clr_flags);
      end
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.empty       = empty_q;
   assign bus.full        = full_q;
   assign bus.almost_full = afull_q;
   assign bus.count       = count_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

endmodule
